// File: rtl/elm_mac_accum_if.sv
// Product-stream / result handshake bundle for elm_mac_accum.
// slave = accumulator side, master = upstream producer plus result consumer.
interface elm_mac_accum_if #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
);
   logic             s_valid;
   logic             s_ready;
   logic [31:0]      s_p;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [ACC_W-1:0] m_acc;
   logic [CNT_W-1:0] m_count;
   logic             m_sat;

   modport slave (
      input  s_valid, s_p, s_last, m_ready,
      output s_ready, m_valid, m_acc, m_count, m_sat
   );

   modport master (
      output s_valid, s_p, s_last, m_ready,
      input  s_ready, m_valid, m_acc, m_count, m_sat
   );
endinterface

// File: rtl/elm_mac_accum.sv
// Streaming dot-product accumulator behind the ELM 16x16 multiplier; one result per vector.
// ELM_ACC_SAT_EN selects saturating accumulation with m_sat reporting; otherwise the sum wraps.
module elm_mac_accum #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
) (
   input logic          clk,
   input logic          rst,
   elm_mac_accum_if.slave bus
);
   typedef enum logic {ACC, HOLD} state_t;

   state_t           state_q, state_d;
   logic             accept;
   logic [ACC_W-1:0] acc_q, m_acc_q;
   logic [ACC_W-1:0] p_ext, raw, sum;
   logic [CNT_W-1:0] cnt_q, cnt_inc, m_count_q;

   assign p_ext   = {{(ACC_W-32){bus.s_p[31]}}, bus.s_p};
   assign raw     = acc_q + p_ext;
   // Beat counter sticks at all-ones instead of wrapping.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef ELM_ACC_SAT_EN
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic clamp, sat_q, m_sat_q;

   // Overflow only when both operands share a sign and the sum flips it.
   assign clamp = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (raw[ACC_W-1] != acc_q[ACC_W-1]);
   assign sum   = clamp ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         sat_q   <= 1'b0;
         m_sat_q <= 1'b0;
      end else if (accept) begin
         if (bus.s_last) begin
            m_sat_q <= sat_q | clamp;
            sat_q   <= 1'b0;
         end else begin
            sat_q   <= sat_q | clamp;
         end
      end
   end

   assign bus.m_sat = m_sat_q;
`else
   assign sum       = raw;
   assign bus.m_sat = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= ACC;
      else     state_q <= state_d;
   end

   // Handshake outputs come from state alone; s_ready never looks at m_ready.
   always_comb begin
      state_d     = state_q;
      bus.s_ready = 1'b0;
      bus.m_valid = 1'b0;
      accept      = 1'b0;
      case (state_q)
         ACC: begin
            bus.s_ready = 1'b1;
            accept      = bus.s_valid;
            if (bus.s_valid && bus.s_last) state_d = HOLD;
         end
         HOLD: begin
            bus.m_valid = 1'b1;
            if (bus.m_ready) state_d = ACC;
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         m_acc_q   <= '0;
         m_count_q <= '0;
      end else if (accept) begin
         if (bus.s_last) begin
            m_acc_q   <= sum;
            m_count_q <= cnt_inc;
            acc_q     <= '0;
            cnt_q     <= '0;
         end else begin
            acc_q     <= sum;
            cnt_q     <= cnt_inc;
         end
      end
   end

   assign bus.m_acc   = m_acc_q;
   assign bus.m_count = m_count_q;
endmodule

// File: tb/tb_elm_mac_accum.sv
// Bench for elm_mac_accum: two instances (40/8 and 33/2) share one stimulus stream,
// checked against fixed vectors, hand sequences and a wide-integer reference model.
module tb_elm_mac_accum;
   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, s_last, m_ready;
   logic [31:0] s_p;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   elm_mac_accum_if #(.ACC_W(40), .CNT_W(8)) bus_a ();
   elm_mac_accum_if #(.ACC_W(33), .CNT_W(2)) bus_b ();

   assign bus_a.s_valid = s_valid;
   assign bus_a.s_p     = s_p;
   assign bus_a.s_last  = s_last;
   assign bus_a.m_ready = m_ready;
   assign bus_b.s_valid = s_valid;
   assign bus_b.s_p     = s_p;
   assign bus_b.s_last  = s_last;
   assign bus_b.m_ready = m_ready;

   elm_mac_accum #(.ACC_W(40), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   elm_mac_accum #(.ACC_W(33), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   typedef struct packed {
      logic [15:0][31:0] beats;
      int     n;
      int     gap;
      int     rdel;
      longint ea;
      longint ca;
      logic   sa;
      longint eb;
      longint cb;
      logic   sb;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Sum beat by beat in 64-bit integers, then clamp or fold back into aw bits.
   function automatic void model(input logic [15:0][31:0] b, input int n, input int aw,
                                 input int cw, output longint acc, output longint cnt,
                                 output logic sat);
      longint mx, mn, cmax;
      mx   = (longint'(1) <<< (aw - 1)) - 1;
      mn   = -mx - 1;
      acc  = 0;
      sat  = 1'b0;
      for (int i = 0; i < n; i++) begin
         acc = acc + longint'($signed(b[i]));
`ifdef ELM_ACC_SAT_EN
         if (acc > mx) begin acc = mx; sat = 1'b1; end
         else if (acc < mn) begin acc = mn; sat = 1'b1; end
`else
         acc = (acc <<< (64 - aw)) >>> (64 - aw);
`endif
      end
      cmax = (longint'(1) <<< cw) - 1;
      cnt  = (n > cmax) ? cmax : longint'(n);
      if (mx < mn) sat = 1'b1;
   endfunction

   task automatic put_beat(input logic [31:0] p, input logic last);
      int k = 0;
      s_valid = 1'b1;
      s_p     = p;
      s_last  = last;
      @(negedge clk);
      while (!bus_a.s_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) chk("s_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic chk_out(input string nm, input longint ea, input longint ca, input logic sa,
                          input longint eb, input longint cb, input logic sb);
      chk({nm, "_acc_a"}, longint'($signed(bus_a.m_acc)), ea);
      chk({nm, "_cnt_a"}, longint'(bus_a.m_count), ca);
      chk({nm, "_sat_a"}, longint'(bus_a.m_sat), longint'(sa));
      chk({nm, "_acc_b"}, longint'($signed(bus_b.m_acc)), eb);
      chk({nm, "_cnt_b"}, longint'(bus_b.m_count), cb);
      chk({nm, "_sat_b"}, longint'(bus_b.m_sat), longint'(sb));
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      m_ready = (v.rdel == 0);
      for (int i = 0; i < v.n; i++) begin
         if (i > 0) repeat (v.gap) begin @(posedge clk); #1; end
         put_beat(v.beats[i], i == v.n - 1);
      end
      chk({nm, "_valid_lat"}, longint'(bus_a.m_valid), 1);
      for (int c = 0; c < v.rdel; c++) begin
         @(posedge clk);
         #1;
         chk({nm, "_hold_valid"}, longint'(bus_a.m_valid & bus_b.m_valid), 1);
         chk({nm, "_hold_sready"}, longint'(bus_a.s_ready | bus_b.s_ready), 0);
      end
      chk_out(nm, v.ea, v.ca, v.sa, v.eb, v.cb, v.sb);
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({nm, "_released"}, longint'({bus_a.m_valid, bus_a.s_ready, bus_b.m_valid, bus_b.s_ready}), 5);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t   rv;
      longint ea, ca, eb, cb;
      logic   sa, sb;

      tbl[0] = '{beats:'0, n:4, gap:0, rdel:0, ea:4, ca:4, sa:0, eb:4, cb:3, sb:0};
      tbl[0].beats[3:0] = {32'd10, 32'hFFFFFFFB, 32'h80000000, 32'h7FFFFFFF};
      tbl[1] = '{beats:'0, n:1, gap:0, rdel:0, ea:-7, ca:1, sa:0, eb:-7, cb:1, sb:0};
      tbl[1].beats[0] = 32'hFFFFFFF9;
      tbl[2] = '{beats:'0, n:3, gap:2, rdel:0, ea:3, ca:3, sa:0, eb:3, cb:3, sb:0};
      tbl[2].beats[2:0] = {32'd1, 32'd1, 32'd1};
`ifdef ELM_ACC_SAT_EN
      tbl[3] = '{beats:'0, n:3, gap:0, rdel:0, ea:64'sd6442450941, ca:3, sa:0,
                 eb:64'sd4294967295, cb:3, sb:1};
      tbl[4] = '{beats:'0, n:3, gap:1, rdel:2, ea:-64'sd6442450944, ca:3, sa:0,
                 eb:-64'sd4294967296, cb:3, sb:1};
`else
      tbl[3] = '{beats:'0, n:3, gap:0, rdel:0, ea:64'sd6442450941, ca:3, sa:0,
                 eb:-64'sd2147483651, cb:3, sb:0};
      tbl[4] = '{beats:'0, n:3, gap:1, rdel:2, ea:-64'sd6442450944, ca:3, sa:0,
                 eb:64'sd2147483648, cb:3, sb:0};
`endif
      tbl[3].beats[2:0] = {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
      tbl[4].beats[2:0] = {32'h80000000, 32'h80000000, 32'h80000000};
      tbl[5] = '{beats:'0, n:6, gap:0, rdel:0, ea:6, ca:6, sa:0, eb:6, cb:3, sb:0};
      tbl[5].beats[5:0] = {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
      tbl[6] = '{beats:'0, n:2, gap:0, rdel:5, ea:11, ca:2, sa:0, eb:11, cb:2, sb:0};
      tbl[6].beats[1:0] = {32'd6, 32'd5};

      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_p = '0; m_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      chk("reset_sready", longint'(bus_a.s_ready & bus_b.s_ready), 1);
      chk("reset_mvalid", longint'(bus_a.m_valid | bus_b.m_valid), 0);
      chk_out("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Partial vector discarded by a two-cycle reset.
      put_beat(32'd1000, 1'b0);
      put_beat(32'd2000, 1'b0);
      put_beat(32'd3000, 1'b0);
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      rv = '{beats:'0, n:2, gap:0, rdel:0, ea:300, ca:2, sa:0, eb:300, cb:2, sb:0};
      rv.beats[1:0] = {32'd200, 32'd100};
      run_vec("post_reset", rv);

      // Held result dropped by reset.
      m_ready = 1'b0;
      put_beat(32'd42, 1'b1);
      chk("hold_before_rst", longint'(bus_a.m_valid), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("hold_dropped", longint'(bus_a.m_valid | bus_b.m_valid), 0);
      chk_out("hold_dropped", 0, 0, 0, 0, 0, 0);
      m_ready = 1'b1;

      foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

      // Backpressure with the next beat already waiting on s_valid.
      m_ready = 1'b0;
      put_beat(32'd20, 1'b0);
      put_beat(32'd22, 1'b1);
      s_valid = 1'b1; s_p = 32'd9; s_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_sready", longint'(bus_a.s_ready | bus_b.s_ready), 0);
         chk("bp_acc_stable", longint'($signed(bus_a.m_acc)), 42);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_next_ready", longint'(bus_a.s_ready & bus_b.s_ready), 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_last = 1'b0;
      chk("bp_next_valid", longint'(bus_a.m_valid & bus_b.m_valid), 1);
      chk_out("bp_next", 9, 1, 0, 9, 1, 0);
      @(posedge clk);
      #1;

      for (int r = 0; r < 40; r++) begin
         rv       = '0;
         rv.n     = int'($urandom_range(1, 12));
         rv.gap   = int'($urandom_range(0, 2));
         rv.rdel  = int'($urandom_range(0, 3));
         for (int i = 0; i < rv.n; i++) begin
            case ($urandom_range(0, 3))
               0: rv.beats[i] = $urandom;
               1: rv.beats[i] = 32'h7FFFFFFF;
               2: rv.beats[i] = 32'h80000000;
               default: rv.beats[i] = $urandom_range(0, 100) - 32'd50;
            endcase
         end
         model(rv.beats, rv.n, 40, 8, ea, ca, sa);
         model(rv.beats, rv.n, 33, 2, eb, cb, sb);
         rv.ea = ea; rv.ca = ca; rv.sa = sa;
         rv.eb = eb; rv.cb = cb; rv.sb = sb;
         run_vec($sformatf("rand%0d", r), rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
